regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised successor to the 32x32 MIPS register file: configurable width and depth, 2 async read ports, 1 sync write port.
- Adds a synchronous clear of all registers.
- Adds optional write-to-read bypass.
- Adds a per-register pending scoreboard: the decode stage reserves a destination register; the writeback stage clears the reservation. The hazard unit uses this to stall dependent instructions.

Parameters:
- WIDTH, 32, data bits per register.
- ADDR_BITS, 5, address width; depth = 2**ADDR_BITS.
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and never goes pending.
- BYPASS, 1, 1 = read of the register being written this cycle returns WriteData.

Ports:
- Clk  input  1  clock, positive-edge.
- Reset  input  1  synchronous, active-high; clears all registers and pending bits.
- ReadRegister1  input  ADDR_BITS  read port 1 address.
- ReadRegister2  input  ADDR_BITS  read port 2 address.
- ReadData1  output  WIDTH  read port 1 data, async.
- ReadData2  output  WIDTH  read port 2 data, async.
- Pending1  output  1  pending bit of ReadRegister1 (after bypass rule).
- Pending2  output  1  pending bit of ReadRegister2 (after bypass rule).
- WriteRegister  input  ADDR_BITS  write address.
- WriteData  input  WIDTH  write data.
- RegWrite  input  1  write enable.
- ReserveRegister  input  ADDR_BITS  register to mark pending.
- Reserve  input  1  reserve enable.
- AnyPending  output  1  OR of all pending bits.

Behaviour:
- Interface: one clock, Clk; reset is synchronous and active-high, named Reset.
- Reset: on a rising Clk with Reset=1, every register becomes 0 and every pending bit becomes 0.
  - Reset dominates RegWrite and Reserve in the same cycle.
  - Outputs after reset: ReadData1/2=0, Pending1/2=0, AnyPending=0.
- Write: on a rising Clk with RegWrite=1, the register at WriteRegister loads WriteData. The new value is visible on the read ports from the following cycle; 0 cycles of read latency after the edge.
- Reads: combinational from the current register contents. Any address in range is legal.
- Bypass (BYPASS=1): if RegWrite=1 and ReadRegisterN==WriteRegister (excluding register 0 when ZERO_REG=1):
  - ReadDataN = WriteData in the same cycle.
  - PendingN = 0.
- Bypass off (BYPASS=0): the read returns the old value until after the edge, and PendingN reflects the stored bit.
- Scoreboard:
  - Rising Clk with Reserve=1: pending[ReserveRegister] is set to 1.
  - Rising Clk with RegWrite=1: pending[WriteRegister] is cleared to 0.
  - Reserve and RegWrite to the same register in the same cycle: the data is written AND the pending bit ends at 1. The new producer wins.
  - Reserve and RegWrite to different registers: both take effect.
  - Reserve of an already-pending register: stays 1; no counting.
  - Write to a non-pending register: legal; the data is written and pending stays 0.
- ZERO_REG=1:
  - ReadData for address 0 is always 0, bypass included.
  - Writes to register 0 are discarded.
  - Reserve of register 0 is ignored; Pending for address 0 is always 0.
- ZERO_REG=0: register 0 behaves like any other register.
- AnyPending: combinational OR of the stored pending bits; no bypass applied.
- Registered state: WIDTH x 2**ADDR_BITS data bits plus 2**ADDR_BITS pending bits. All updates occur only on the rising Clk edge.

Test Plan:
- Reset=1 for one edge after writing 0xDEADBEEF to register 7 -> read of register 7 gives 0x00000000; AnyPending=0.
- RegWrite=1, WriteRegister=5, WriteData=0x12345678, ReadRegister1=5, BYPASS=1 -> ReadData1=0x12345678 in the same cycle. With BYPASS=0 -> old value (0) before the edge, 0x12345678 after it.
- Reserve register 9 -> Pending1=1 and AnyPending=1 with ReadRegister1=9. Next cycle write 0xA5A5A5A5 to register 9 -> Pending1=0 after the edge and ReadData1=0xA5A5A5A5.
- Same cycle: Reserve=1 with ReserveRegister=3, and RegWrite=1 with WriteRegister=3, WriteData=0x00000042 -> after the edge, register 3 = 0x42 and Pending for register 3 = 1.
- ZERO_REG=1: write 0xFFFFFFFF to register 0 and reserve register 0 -> ReadData for address 0 = 0, Pending=0, AnyPending=0. Repeat with ZERO_REG=0 -> reads 0xFFFFFFFF and shows pending.
- WIDTH=16, ADDR_BITS=3: write 0xBEEF to register 7, then register 0x1234 (WriteRegister truncates to 3 bits = 4) -> register 7 reads 0xBEEF; ReadData2 with ReadRegister2=4 reads the 0x1234 data. Assert Reset while register 2 is pending -> Pending cleared and reads return 0.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
//   Parametrised register file with two asynchronous read ports, one
//   synchronous write port, synchronous clear, optional write-to-read bypass
//   and a per-register pending scoreboard used by the hazard unit to stall
//   instructions that depend on a result still in flight.
//
// Parameters
//   WIDTH      data bits per register
//   ADDR_BITS  address width, depth = 2**ADDR_BITS
//   ZERO_REG   1 = register 0 reads as 0, ignores writes, never goes pending
//   BYPASS     1 = a read of the register written this cycle returns WriteData
//
// Ports
//   Clk              clock, rising edge
//   Reset            synchronous active-high clear of data and pending bits
//   ReadRegister1/2  read addresses
//   ReadData1/2      read data (combinational)
//   Pending1/2       pending bit of each read address, after bypass
//   WriteRegister    write address
//   WriteData        write data
//   RegWrite         write enable; also retires the reservation
//   ReserveRegister  destination register to mark pending
//   Reserve          reserve enable
//   AnyPending       OR of all stored pending bits (no bypass)
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
   parameter int WIDTH     = 32,
   parameter int ADDR_BITS = 5,
   parameter bit ZERO_REG  = 1'b1,
   parameter bit BYPASS    = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [ADDR_BITS-1:0] ReadRegister1,
   input  logic [ADDR_BITS-1:0] ReadRegister2,
   output logic [WIDTH-1:0]     ReadData1,
   output logic [WIDTH-1:0]     ReadData2,
   output logic                 Pending1,
   output logic                 Pending2,
   input  logic [ADDR_BITS-1:0] WriteRegister,
   input  logic [WIDTH-1:0]     WriteData,
   input  logic                 RegWrite,
   input  logic [ADDR_BITS-1:0] ReserveRegister,
   input  logic                 Reserve,
   output logic                 AnyPending
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0] pend_q;
   logic [DEPTH-1:0] pend_d;

   logic wr_en;
   logic rsv_en;
   logic zero1, zero2;
   logic byp1, byp2;

   // Register 0 is hard-wired when ZERO_REG is set, so writes and
   // reservations aimed at it are dropped before they reach any state.
   always_comb begin
      wr_en  = RegWrite && !(ZERO_REG && (WriteRegister == '0));
      rsv_en = Reserve  && !(ZERO_REG && (ReserveRegister == '0));
   end

   // Retire first, then reserve: when both hit the same register the new
   // producer's reservation must survive the write of the old result.
   always_comb begin
      pend_d = pend_q;
      if (wr_en) begin
         pend_d[WriteRegister] = 1'b0;
      end
      if (rsv_en) begin
         pend_d[ReserveRegister] = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         if (wr_en) begin
            regs_q[WriteRegister] <= WriteData;
         end
         pend_q <= pend_d;
      end
   end

   // Read ports. wr_en already excludes register 0 under ZERO_REG, so the
   // bypass can never forward a value onto the hard-wired zero.
   always_comb begin
      zero1 = ZERO_REG && (ReadRegister1 == '0);
      zero2 = ZERO_REG && (ReadRegister2 == '0);
      byp1  = BYPASS && wr_en && (ReadRegister1 == WriteRegister);
      byp2  = BYPASS && wr_en && (ReadRegister2 == WriteRegister);
   end

   assign ReadData1 = zero1 ? '0 : (byp1 ? WriteData : regs_q[ReadRegister1]);
   assign ReadData2 = zero2 ? '0 : (byp2 ? WriteData : regs_q[ReadRegister2]);

   // A bypassed read is the value being produced now, so it is not pending.
   assign Pending1 = !zero1 && !byp1 && pend_q[ReadRegister1];
   assign Pending2 = !zero2 && !byp2 && pend_q[ReadRegister2];

   assign AnyPending = |pend_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

   logic        Clk;
   logic        rst, we, rsv;
   logic [15:0] wa, ra, rr1, rr2;
   logic [31:0] wd;

   // A: default (ZERO_REG=1, BYPASS=1); B: ZERO_REG=0, BYPASS=0; C: 16x8
   logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2;
   logic [15:0] c_rd1, c_rd2;
   logic        a_p1, a_p2, a_any, b_p1, b_p2, b_any, c_p1, c_p2, c_any;

   int checks = 0;
   int errors = 0;

   regfile_scoreboard #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
      .Clk(Clk), .Reset(rst),
      .ReadRegister1(rr1[4:0]), .ReadRegister2(rr2[4:0]),
      .ReadData1(a_rd1), .ReadData2(a_rd2), .Pending1(a_p1), .Pending2(a_p2),
      .WriteRegister(wa[4:0]), .WriteData(wd), .RegWrite(we),
      .ReserveRegister(ra[4:0]), .Reserve(rsv), .AnyPending(a_any));

   regfile_scoreboard #(.WIDTH(32), .ADDR_BITS(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .Clk(Clk), .Reset(rst),
      .ReadRegister1(rr1[4:0]), .ReadRegister2(rr2[4:0]),
      .ReadData1(b_rd1), .ReadData2(b_rd2), .Pending1(b_p1), .Pending2(b_p2),
      .WriteRegister(wa[4:0]), .WriteData(wd), .RegWrite(we),
      .ReserveRegister(ra[4:0]), .Reserve(rsv), .AnyPending(b_any));

   regfile_scoreboard #(.WIDTH(16), .ADDR_BITS(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_c (
      .Clk(Clk), .Reset(rst),
      .ReadRegister1(rr1[2:0]), .ReadRegister2(rr2[2:0]),
      .ReadData1(c_rd1), .ReadData2(c_rd2), .Pending1(c_p1), .Pending2(c_p2),
      .WriteRegister(wa[2:0]), .WriteData(wd[15:0]), .RegWrite(we),
      .ReserveRegister(ra[2:0]), .Reserve(rsv), .AnyPending(c_any));

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // ---------------- behavioural reference model ----------------
   int          zr    [3] = '{1, 0, 1};
   int          byp   [3] = '{1, 0, 1};
   int          amask [3] = '{31, 31, 7};
   logic [31:0] dmask [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_FFFF};
   logic [31:0] mem   [3][32];
   bit          pend  [3][32];

   function automatic logic [31:0] m_rd(input int k, input logic [15:0] a);
      int am, wm;
      am = int'(a) & amask[k];
      wm = int'(wa) & amask[k];
      if (zr[k] != 0 && am == 0) return 32'h0;
      if (byp[k] != 0 && we && am == wm) return wd & dmask[k];
      return mem[k][am];
   endfunction

   function automatic logic [31:0] m_pd(input int k, input logic [15:0] a);
      int am, wm;
      am = int'(a) & amask[k];
      wm = int'(wa) & amask[k];
      if (zr[k] != 0 && am == 0) return 32'h0;
      if (byp[k] != 0 && we && am == wm) return 32'h0;
      return {31'b0, pend[k][am]};
   endfunction

   function automatic logic [31:0] m_any(input int k);
      for (int i = 0; i <= amask[k]; i++) if (pend[k][i]) return 32'h1;
      return 32'h0;
   endfunction

   task automatic m_clock();
      for (int k = 0; k < 3; k++) begin
         int wm, rm;
         wm = int'(wa) & amask[k];
         rm = int'(ra) & amask[k];
         if (rst) begin
            for (int i = 0; i < 32; i++) begin
               mem[k][i]  = 32'h0;
               pend[k][i] = 1'b0;
            end
         end else begin
            if (we && !(zr[k] != 0 && wm == 0)) begin
               mem[k][wm]  = wd & dmask[k];
               pend[k][wm] = 1'b0;
            end
            if (rsv && !(zr[k] != 0 && rm == 0)) pend[k][rm] = 1'b1;
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      m_clock();
      #1;
   endtask

   task automatic idle();
      rst = 0; we = 0; rsv = 0; wa = 0; wd = 0; ra = 0;
   endtask

   task automatic check_model(input string tag);
      check({tag, " A.rd1"}, a_rd1, m_rd(0, rr1));
      check({tag, " A.rd2"}, a_rd2, m_rd(0, rr2));
      check({tag, " A.p1"},  {31'b0, a_p1}, m_pd(0, rr1));
      check({tag, " A.p2"},  {31'b0, a_p2}, m_pd(0, rr2));
      check({tag, " A.any"}, {31'b0, a_any}, m_any(0));
      check({tag, " B.rd1"}, b_rd1, m_rd(1, rr1));
      check({tag, " B.rd2"}, b_rd2, m_rd(1, rr2));
      check({tag, " B.p1"},  {31'b0, b_p1}, m_pd(1, rr1));
      check({tag, " B.p2"},  {31'b0, b_p2}, m_pd(1, rr2));
      check({tag, " B.any"}, {31'b0, b_any}, m_any(1));
      check({tag, " C.rd1"}, {16'b0, c_rd1}, m_rd(2, rr1));
      check({tag, " C.rd2"}, {16'b0, c_rd2}, m_rd(2, rr2));
      check({tag, " C.p1"},  {31'b0, c_p1}, m_pd(2, rr1));
      check({tag, " C.p2"},  {31'b0, c_p2}, m_pd(2, rr2));
      check({tag, " C.any"}, {31'b0, c_any}, m_any(2));
   endtask

   // ---------------- directed vector table ----------------
   // Expected values are the outputs seen before the edge that applies the row.
   typedef struct {
      logic        rst, we;
      logic [15:0] wa;
      logic [31:0] wd;
      logic        rsv;
      logic [15:0] ra, rr;
      logic        chk;
      logic [31:0] a_rd;
      logic        a_p, a_any;
      logic [31:0] b_rd;
      logic        b_p, b_any;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic w, input logic [15:0] wadr, input logic [31:0] wdat,
                      input logic s, input logic [15:0] radr, input logic [15:0] rd, input logic c,
                      input logic [31:0] ad, input logic ap, input logic aa,
                      input logic [31:0] bd, input logic bp, input logic ba);
      vec_t v;
      v.rst = r; v.we = w; v.wa = wadr; v.wd = wdat; v.rsv = s; v.ra = radr; v.rr = rd; v.chk = c;
      v.a_rd = ad; v.a_p = ap; v.a_any = aa; v.b_rd = bd; v.b_p = bp; v.b_any = ba;
      vecs.push_back(v);
   endtask

   initial begin
      idle(); rr1 = 0; rr2 = 0;
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 32; i++) begin mem[k][i] = 32'h0; pend[k][i] = 1'b0; end

      //   rst we wa  wd            rsv ra rr chk  A: rd         p  any  B: rd         p  any
      add(1, 0, 0, 32'h0,          0, 0, 0, 0,  32'h0,        0, 0,  32'h0,        0, 0);
      add(0, 1, 7, 32'hDEADBEEF,   0, 0, 7, 1,  32'hDEADBEEF, 0, 0,  32'h0,        0, 0);
      add(1, 0, 0, 32'h0,          0, 0, 7, 1,  32'hDEADBEEF, 0, 0,  32'hDEADBEEF, 0, 0);
      add(0, 0, 0, 32'h0,          0, 0, 7, 1,  32'h0,        0, 0,  32'h0,        0, 0);
      add(0, 1, 5, 32'h12345678,   0, 0, 5, 1,  32'h12345678, 0, 0,  32'h0,        0, 0);
      add(0, 0, 0, 32'h0,          1, 9, 5, 1,  32'h12345678, 0, 0,  32'h12345678, 0, 0);
      add(0, 0, 0, 32'h0,          0, 0, 9, 1,  32'h0,        1, 1,  32'h0,        1, 1);
      add(0, 1, 9, 32'hA5A5A5A5,   0, 0, 9, 1,  32'hA5A5A5A5, 0, 1,  32'h0,        1, 1);
      add(0, 0, 0, 32'h0,          0, 0, 9, 1,  32'hA5A5A5A5, 0, 0,  32'hA5A5A5A5, 0, 0);
      add(0, 1, 3, 32'h42,         1, 3, 3, 1,  32'h42,       0, 0,  32'h0,        0, 0);
      add(0, 0, 0, 32'h0,          0, 0, 3, 1,  32'h42,       1, 1,  32'h42,       1, 1);
      add(0, 1, 0, 32'hFFFFFFFF,   1, 0, 0, 1,  32'h0,        0, 1,  32'h0,        0, 1);
      add(0, 0, 0, 32'h0,          0, 0, 0, 1,  32'h0,        0, 1,  32'hFFFFFFFF, 1, 1);
      add(1, 1, 3, 32'h55,         1, 3, 0, 1,  32'h0,        0, 1,  32'hFFFFFFFF, 1, 1);
      add(0, 0, 0, 32'h0,          0, 0, 3, 1,  32'h0,        0, 0,  32'h0,        0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst = vecs[i].rst; we = vecs[i].we; wa = vecs[i].wa; wd = vecs[i].wd;
         rsv = vecs[i].rsv; ra = vecs[i].ra; rr1 = vecs[i].rr; rr2 = vecs[i].rr;
         #1;
         if (vecs[i].chk) begin
            check($sformatf("vec%0d A.rd1", i), a_rd1, vecs[i].a_rd);
            check($sformatf("vec%0d A.rd2", i), a_rd2, vecs[i].a_rd);
            check($sformatf("vec%0d A.p1", i),  {31'b0, a_p1}, {31'b0, vecs[i].a_p});
            check($sformatf("vec%0d A.p2", i),  {31'b0, a_p2}, {31'b0, vecs[i].a_p});
            check($sformatf("vec%0d A.any", i), {31'b0, a_any}, {31'b0, vecs[i].a_any});
            check($sformatf("vec%0d B.rd1", i), b_rd1, vecs[i].b_rd);
            check($sformatf("vec%0d B.rd2", i), b_rd2, vecs[i].b_rd);
            check($sformatf("vec%0d B.p1", i),  {31'b0, b_p1}, {31'b0, vecs[i].b_p});
            check($sformatf("vec%0d B.p2", i),  {31'b0, b_p2}, {31'b0, vecs[i].b_p});
            check($sformatf("vec%0d B.any", i), {31'b0, b_any}, {31'b0, vecs[i].b_any});
         end
         tick();
      end

      // ---- narrow instance: address truncation and reset of a pending reg ----
      idle(); we = 1; wa = 16'd7; wd = 32'h0000BEEF;
      tick();
      wa = 16'h1234; wd = 32'h00001234;
      tick();
      idle(); rr1 = 16'd7; rr2 = 16'd4;
      #1;
      check("C trunc rd1", {16'b0, c_rd1}, 32'h0000BEEF);
      check("C trunc rd2", {16'b0, c_rd2}, 32'h00001234);
      rsv = 1; ra = 16'd2;
      tick();
      idle(); rr2 = 16'd2;
      #1;
      check("C pend2 set", {31'b0, c_p2}, 32'h1);
      check("C any set",   {31'b0, c_any}, 32'h1);
      rst = 1;
      tick();
      idle();
      #1;
      check("C pend2 rst", {31'b0, c_p2}, 32'h0);
      check("C any rst",   {31'b0, c_any}, 32'h0);
      check("C rd1 rst",   {16'b0, c_rd1}, 32'h0);
      check("A any rst",   {31'b0, a_any}, 32'h0);

      // ---- randomized run against the reference model ----
      for (int n = 0; n < 1500; n++) begin
         rst = ($urandom_range(0, 63) == 0);
         we  = $urandom_range(0, 1);
         rsv = $urandom_range(0, 1);
         wa  = 16'($urandom);
         wd  = $urandom;
         ra  = ($urandom_range(0, 3) == 0) ? wa : 16'($urandom);
         rr1 = ($urandom_range(0, 3) == 0) ? wa : 16'($urandom);
         rr2 = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
         if ($urandom_range(0, 7) == 0) rr1 = 16'h0;
         #1;
         check_model($sformatf("rnd%0d", n));
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
